// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants, FSM states and pipeline tag for the matmul sequencer
package matmul_pkg;
    localparam int MAX_SIZE = 10;
    localparam int ADDR_W   = 7;
    localparam int IDX_W    = $clog2(MAX_SIZE + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic              valid;
        logic              first_k;
        logic              last_k;
        logic [ADDR_W-1:0] r_addr;
    } tag_t;
endpackage

// File: rtl/matmul_idx_counter.sv
// matmul_idx_counter: nested k/j/i counter with incremental A, B and result address bases
module matmul_idx_counter
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    input  logic [IDX_W-1:0]  n,
    output logic [IDX_W-1:0]  k,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] r_addr,
    output logic              last
);
    logic [IDX_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d, nm1;
    logic [ADDR_W-1:0] a_q, a_d, b_q, b_d, base_q, base_d, n_w;
    logic              k_wrap, j_wrap, i_wrap;

    assign nm1    = n - 1'b1;
    assign n_w    = ADDR_W'(n);
    assign k_wrap = k_q == nm1;
    assign j_wrap = j_q == nm1;
    assign i_wrap = i_q == nm1;
    assign k      = k_q;
    assign a_addr = a_q;
    assign b_addr = b_q;
    assign r_addr = base_q + ADDR_W'(j_q);
    assign last   = k_wrap && j_wrap && i_wrap;

    // advance k innermost; a tracks i*N+k, b tracks k*N+j, base tracks i*N
    always_comb begin
        i_d    = i_q;
        j_d    = j_q;
        k_d    = k_q;
        a_d    = a_q;
        b_d    = b_q;
        base_d = base_q;
        if (clear) begin
            i_d    = '0;
            j_d    = '0;
            k_d    = '0;
            a_d    = '0;
            b_d    = '0;
            base_d = '0;
        end else if (step) begin
            if (!k_wrap) begin
                k_d = k_q + 1'b1;
                a_d = a_q + 1'b1;
                b_d = b_q + n_w;
            end else if (!j_wrap) begin
                k_d = '0;
                j_d = j_q + 1'b1;
                a_d = base_q;
                b_d = ADDR_W'(j_q) + 1'b1;
            end else if (!i_wrap) begin
                k_d    = '0;
                j_d    = '0;
                i_d    = i_q + 1'b1;
                base_d = base_q + n_w;
                a_d    = base_q + n_w;
                b_d    = '0;
            end else begin
                i_d    = '0;
                j_d    = '0;
                k_d    = '0;
                a_d    = '0;
                b_d    = '0;
                base_d = '0;
            end
        end
    end

    // index and address registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            base_q <= '0;
        end else begin
            i_q    <= i_d;
            j_q    <= j_d;
            k_q    <= k_d;
            a_q    <= a_d;
            b_q    <= b_d;
            base_q <= base_d;
        end
    end
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: i/j/k loop sequencer driving operand reads, MAC control and result writes; MATSEQ_HOLD_EN adds a hold stall input
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        size,
`ifdef MATSEQ_HOLD_EN
    input  logic              hold,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  n_q, n_d, k;
    logic              cnt_q, cnt_d, err_q, err_d, frozen, step, last, legal;
    tag_t              s2_q, s2_d, s3_q, s3_d;
    logic [ADDR_W-1:0] r_base;

`ifdef MATSEQ_HOLD_EN
    assign frozen = hold && (state_q == RUN || state_q == DRAIN);
`else
    assign frozen = 1'b0;
`endif
    assign step    = state_q == RUN && !frozen;
    assign legal   = size != 8'd0 && size <= 8'(MAX_SIZE);
    assign rd_en   = step;
    assign mac_en  = s2_q.valid && !frozen;
    assign mac_clr = mac_en && s2_q.first_k;
    assign r_we    = s3_q.valid && s3_q.last_k && !frozen;
    assign r_addr  = s3_q.r_addr;
    assign busy    = state_q == LOAD || state_q == RUN || state_q == DRAIN;
    assign done    = state_q == DONE;
    assign err     = err_q;

    matmul_idx_counter u_idx (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == LOAD),
        .step   (step),
        .n      (n_q),
        .k      (k),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .r_addr (r_base),
        .last   (last)
    );

    // control FSM: accept/reject start, run the loop nest, flush two stages, pulse done
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && legal) begin
                    state_d = LOAD;
                    n_d     = size[IDX_W-1:0];
                end
                err_d = start && !legal;
            end
            LOAD:    state_d = RUN;
            RUN: begin
                if (step && last) begin
                    state_d = DRAIN;
                    cnt_d   = 1'b0;
                end
            end
            DRAIN: begin
                if (!frozen) begin
                    cnt_d   = !cnt_q;
                    state_d = cnt_q ? DONE : DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // issue tags travel to the MAC stage then the write stage; held as a whole when frozen
    always_comb begin
        s2_d = s2_q;
        s3_d = s3_q;
        if (!frozen) begin
            s2_d.valid   = step;
            s2_d.first_k = k == '0;
            s2_d.last_k  = k == n_q - 1'b1;
            s2_d.r_addr  = r_base;
            s3_d         = s2_q;
        end
    end

    // state, latched size and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= 1'b0;
            err_q   <= 1'b0;
            s2_q    <= '0;
            s3_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
        end
    end
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed bench with operand RAM/MAC environment and result scoreboard
module tb_matmul_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] size = 8'd0;
`ifdef MATSEQ_HOLD_EN
    logic       hold = 1'b0;
`endif
    logic       rd_en, mac_clr, mac_en, r_we, busy, done, err;
    logic [6:0] a_addr, b_addr, r_addr;

    typedef struct {int a; int b;} iss_t;
    typedef struct {int addr; int val;} res_t;

    iss_t iss_q[$];
    res_t exp_q[$];
    iss_t ie;
    res_t re;
    int   a_mem[128];
    int   b_mem[128];
    int   a_dout, b_dout, acc;
    int   cyc = 0, t0 = 0, iss_seen = 0, err_cnt = 0, done_cnt = 0;
    int   checks = 0, errors = 0;
    int   base, e0, d0;

    matmul_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .size    (size),
`ifdef MATSEQ_HOLD_EN
        .hold    (hold),
`endif
        .rd_en   (rd_en),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .mac_clr (mac_clr),
        .mac_en  (mac_en),
        .r_we    (r_we),
        .r_addr  (r_addr),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en) begin
            a_dout <= a_mem[a_addr];
            b_dout <= b_mem[b_addr];
        end
        if (mac_en) acc <= mac_clr ? a_dout * b_dout : acc + a_dout * b_dout;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_en) begin
            iss_seen++;
            check("issue_expected", iss_q.size() != 0, 1);
            if (iss_q.size() != 0) begin
                ie = iss_q.pop_front();
                check("a_addr", a_addr, ie.a);
                check("b_addr", b_addr, ie.b);
            end
        end
        if (r_we) begin
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                re = exp_q.pop_front();
                check("r_addr", r_addr, re.addr);
                check("r_data", acc, re.val);
            end
        end
        if (err) err_cnt++;
        if (done) done_cnt++;
    end

    task automatic check_quiet();
        check("rst_rd_en", rd_en, 0);
        check("rst_a_addr", a_addr, 0);
        check("rst_b_addr", b_addr, 0);
        check("rst_mac_clr", mac_clr, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_r_we", r_we, 0);
        check("rst_r_addr", r_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    task automatic start_run(input int n);
        int s;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    iss_q.push_back('{i * n + k, k * n + j});
                    s += a_mem[i * n + k] * b_mem[k * n + j];
                end
                exp_q.push_back('{i * n + j, s});
            end
        @(negedge clk);
        start = 1'b1;
        size  = 8'(n);
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        size  = 8'hEE;
    endtask

    task automatic wait_done(input int n, input int extra);
        int lat;
        lat = -1;
        for (int t = 0; t < 3000 && lat < 0; t++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - t0;
                check("done_busy", busy, 0);
            end
        end
        check("latency", lat, n * n * n + 3 + extra);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("writes_left", exp_q.size(), 0);
        check("issues_left", iss_q.size(), 0);
    endtask

    task automatic wait_issues(input int target);
        bit hit;
        hit = 1'b0;
        for (int t = 0; t < 3000 && !hit; t++) begin
            @(negedge clk);
            #1;
            hit = iss_seen >= target;
        end
        check("wait_issues", iss_seen, target);
    endtask

    task automatic illegal(input int s);
        e0 = err_cnt;
        @(negedge clk);
        start = 1'b1;
        size  = 8'(s);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("busy_illegal", busy, 0);
        end
        check("err_pulses", err_cnt - e0, 1);
    endtask

    initial begin
        #1;
        check_quiet();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        a_mem[0:3] = '{1, 2, 3, 4};
        b_mem[0:3] = '{5, 6, 7, 8};
        start_run(2);
        @(negedge clk);
        start = 1'b1;
        size  = 8'd3;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(2, 0);

        for (int i = 0; i < 100; i++) begin
            a_mem[i] = 1;
            b_mem[i] = 1;
        end
        start_run(10);
        wait_done(10, 0);

        illegal(0);
        illegal(11);

        a_mem[0] = 7;
        b_mem[0] = 9;
        start_run(1);
        wait_done(1, 0);

        for (int i = 0; i < 9; i++) begin
            a_mem[i] = i + 1;
            b_mem[i] = 9 - i;
        end
        start_run(3);
        base = iss_seen;
        wait_issues(base + 10);
        rst = 1'b1;
        #1;
        check_quiet();
        iss_q.delete();
        exp_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        start_run(3);
        wait_done(3, 0);

`ifdef MATSEQ_HOLD_EN
        start_run(3);
        base = iss_seen;
        wait_issues(base + 5);
        @(posedge clk);
        #1;
        hold = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        hold = 1'b0;
        wait_issues(base + 27);
        @(posedge clk);
        #1;
        hold = 1'b1;
        @(posedge clk);
        #1;
        hold = 1'b0;
        wait_done(3, 6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Control sequencer for the matrix-multiply datapath. It walks the i/j/k loop nest for a runtime-selected NxN product (N up to MAX_SIZE). It issues read addresses to the A and B operand buffers, drives clear/enable of the external MAC accumulator, and issues write strobes for the result buffer. It sits between the UART host-side loader (which fills A/B and pulses start) and the result transmitter (which waits for done).

Parameters:
MAX_SIZE, 10, largest legal N.
ADDR_W, 7, operand/result address width; must satisfy 2^ADDR_W >= MAX_SIZE*MAX_SIZE.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin a multiply; sampled only in IDLE.
size  input  8  N; latched when start is accepted.
rd_en  output  1  operand read strobe to A and B buffers (1-cycle synchronous read).
a_addr  output  ADDR_W  A address, equals i*N+k.
b_addr  output  ADDR_W  B address, equals k*N+j.
mac_clr  output  1  MAC loads the product (acc <= a*b) instead of accumulating.
mac_en  output  1  MAC updates this cycle.
r_we  output  1  result write strobe; data is the MAC accumulator.
r_addr  output  ADDR_W  result address, equals i*N+j.
busy  output  1  high from start acceptance until done.
done  output  1  one-cycle completion pulse.
err  output  1  one-cycle pulse on an illegal size.

Behaviour:
- Reset (async): state IDLE, every output 0, indices 0, latched N 0, pipeline valids cleared. Reset mid-run aborts with no done and no further writes.
- States:
  - IDLE: start=1 with 1<=size<=MAX_SIZE → LOAD. Latch N, busy<=1.
  - IDLE: start=1 with size 0 or >MAX_SIZE → err pulses 1 cycle, remain IDLE.
  - LOAD: zero i, j, k and address bases → RUN.
  - RUN: one issue per cycle with rd_en=1; k is innermost, then j, then i. After the issue with i=j=k=N-1 → DRAIN.
  - DRAIN: 2 cycles to flush the pipeline → DONE.
  - DONE: done=1 and busy=0 for one cycle → IDLE.
- Addresses are formed incrementally (adders only, no multipliers). The issued values must equal the formulas above.
- Pipeline:
  - Stage 1 is the issue cycle: rd_en and addresses.
  - Stage 2 (+1 cycle), when operand data is valid: mac_en=1; mac_clr=1 iff the issued k was 0.
  - Stage 3 (+2 cycles): r_we=1 iff the issued k was N-1; r_addr carries that issue's i*N+j.
- Exactly N^2 r_we pulses, in row-major order, per run.
- Latency: done is high in the cycle N^3+3 clocks after the clock edge that accepted start. N=1 gives 4; N=10 gives 1003.
- start while busy is ignored. A change of size after acceptance has no effect.
- Start asserted in the DONE cycle is ignored; it is accepted the following cycle in IDLE if still high.
- N=1: one issue, mac_clr and r_we both derived from the same issue (k=0=N-1).

Optional Feature:
MATSEQ_HOLD_EN
- Defined: adds input port hold (1 bit). While hold=1:
  - RUN and DRAIN freeze: indices, pipeline registers and DRAIN count are all held.
  - rd_en, mac_en and r_we are forced to 0.
  - Operand buffers must retain their output data while rd_en=0.
  - On release, the sequence resumes with no skipped or repeated issue. Latency grows by exactly the number of held cycles.
  - hold has no effect in IDLE, LOAD or DONE.
  - Purpose: lets the UART loader borrow buffer ports mid-run.
- Undefined: no hold port; the sequence is never stalled.

Decomposition:
- Package matmul_pkg holds:
  - MAX_SIZE and ADDR_W constants.
  - The state enum (IDLE, LOAD, RUN, DRAIN, DONE).
  - A pipeline-tag struct {valid, first_k, last_k, r_addr}.
- Sub-module matmul_idx_counter: the nested k/j/i counter with wrap carries and incremental a/b/r address bases. It has inputs clear and step; outputs are the indices, the three addresses, and last.

Test Plan:
- N=2; A=[1 2;3 4], B=[5 6;7 8] with a behavioural RAM+MAC model → r_we at addrs 0,1,2,3 with values 19,22,43,50; done 11 cycles after start.
- N=10, A=B=all 1 → 100 writes, every value 10; done at cycle 1003; check a_addr/b_addr against the formulas at every issue.
- size=0, then size=11 → err pulse each time, busy stays 0, no rd_en.
- N=1, A[0]=7, B[0]=9 → a single issue with mac_clr and r_we (addr 0, value 63); done at cycle 4.
- N=3, rst asserted at issue 10 → all outputs 0 asynchronously, no done; a subsequent start with N=3 runs cleanly.
- MATSEQ_HOLD_EN, N=3: hold for 5 cycles during RUN and 1 cycle during DRAIN → results identical to the unheld run; done at cycle 30+6=36.
